axis_pkt_gen: RTL and testbench
===============================

// Module: axis_pkt_gen
// PURPOSE
//  AXI-Stream packet source: drives a master AXIS port with framed packets of programmable byte length,
//  deterministic byte-incrementing payload, inter-packet gap and packet count. Front end of the stream
//  datapath for bring-up, loopback and for feeding register slices and sinks under test.
// PARAMETERS
//  BYTE_WIDTH   4    bytes per beat (TDATA = 8*BYTE_WIDTH bits, TKEEP = BYTE_WIDTH bits); >=1
//  SIZE_WIDTH   16   width of PACKET_SIZE (bytes)
//  CNT_WIDTH    32   width of PACKET_LIMIT and PACKET_CNT
//  GAP_WIDTH    8    width of GAP_CYCLES
// PORTS
//  CLK            in   1             clock, all logic on rising edge
//  RESET          in   1             synchronous, active-high reset
//  START          in   1             pulse; starts a run when idle, ignored when BUSY=1
//  STOP           in   1             level/pulse; finish current packet, then stop
//  PACKET_SIZE    in   SIZE_WIDTH    bytes per packet; 0 treated as 1; latched on START
//  PACKET_LIMIT   in   CNT_WIDTH     packets per run; 0 = unlimited; latched on START
//  GAP_CYCLES     in   GAP_WIDTH     idle cycles between packets; latched on START
//  BUSY           out  1             1 from cycle after START until run ends
//  PACKET_CNT     out  CNT_WIDTH     packets completed since reset, wraps modulo 2^CNT_WIDTH
//  M_AXIS_TDATA   out  8*BYTE_WIDTH  payload
//  M_AXIS_TKEEP   out  BYTE_WIDTH    byte enables
//  M_AXIS_TVALID  out  1             beat valid
//  M_AXIS_TREADY  in   1             downstream ready
//  M_AXIS_TLAST   out  1             last beat of packet
// BEHAVIOUR
//  - Reset (sync, active-high): state IDLE; TVALID, TLAST, TDATA, TKEEP, BUSY, PACKET_CNT all 0; latched config cleared.
//    Reset mid-packet abandons packet immediately; no TLAST is produced for it.
//  - FSM: IDLE -> DATA on START (BUSY=1, TVALID=1 the next cycle, latency 1).
//    DATA -> on TLAST handshake: PACKET_CNT+1; if run done (limit reached or STOP seen) -> IDLE;
//    else GAP_CYCLES=0 -> stay DATA (next packet back-to-back); else -> GAP.
//    GAP: TVALID=0, down-counter from GAP_CYCLES; exactly GAP_CYCLES idle cycles, then DATA (or IDLE if STOP seen).
//  - STOP is sticky once sampled while BUSY; cleared on return to IDLE. STOP in IDLE ignored; START+STOP same cycle in IDLE: start, run one packet.
//  - Handshake: beat transfers on TVALID&TREADY. Once TVALID=1 it stays 1 and TDATA/TKEEP/TLAST stay stable until transfer.
//    TVALID never depends combinationally on TREADY; all outputs registered.
//  - Beats per packet = ceil(size/BYTE_WIDTH). Payload byte i of beat b = (b*BYTE_WIDTH+i) mod 256, restarting at 0 each packet.
//  - TKEEP = all ones except last beat: low (size mod BYTE_WIDTH) bits set, all ones if remainder 0. Unused bytes of last beat driven 0.
//  - TLAST = 1 only on last beat. Single-beat packets (size<=BYTE_WIDTH) have TLAST=1 on their only beat.
//  - PACKET_LIMIT counter per run; unlimited runs end only by STOP or RESET. PACKET_CNT wraps, no saturation.
//  - BUSY falls the cycle after the final TLAST handshake (or after final GAP cycle with STOP seen).
// CONFIGURATION
//  AXIS_PKT_GEN_SEQ_HEADER_EN defined: first beat of each packet carries in its low min(32,8*BYTE_WIDTH) bits
//   the current PACKET_CNT value (pre-increment), little-endian, overriding the pattern in those bytes only;
//   TKEEP unchanged. Remaining bytes and beats keep the incrementing pattern.
//  Not defined: pure incrementing pattern on all beats; no header logic synthesized.
// TESTING (BYTE_WIDTH=4, macro undefined unless stated)
//  1) SIZE=10, LIMIT=1, GAP=0, TREADY=1, START -> 3 beats 0x03020100/F, 0x07060504/F, 0x00000908/3 TLAST; PACKET_CNT=1; BUSY=0 after.
//  2) Same with TREADY random 50% -> identical beat sequence; TDATA/TKEEP/TLAST/TVALID stable during every stall.
//  3) SIZE=8, LIMIT=3, GAP=2 -> 3 packets of 2 beats, last TKEEP=F; exactly 2 TVALID=0 cycles between TLAST and next beat; PACKET_CNT=3.
//  4) LIMIT=0, SIZE=16, STOP pulsed during packet 2 beat 1 -> packet 2 completes with TLAST; no packet 3; BUSY drops; PACKET_CNT=2.
//  5) RESET during packet beat 2 -> next cycle TVALID=0, BUSY=0, PACKET_CNT=0; new START restarts at 0x03020100.
//  6) SIZE=0 -> single beat TKEEP=0x1, TLAST=1, TDATA=0x00000000; with AXIS_PKT_GEN_SEQ_HEADER_EN, SIZE=8, LIMIT=2 -> first beats 0x00000000, 0x00000001.

Source files
------------

// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream packet source with programmable size, count and
// inter-packet gap; payload bytes increment from 0 at the start of each packet.
// Optional feature macro: AXIS_PKT_GEN_SEQ_HEADER_EN puts the running packet
// count in the low bytes of each packet's first beat.
module axis_pkt_gen #(
    parameter int unsigned BYTE_WIDTH = 4,
    parameter int unsigned SIZE_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned GAP_WIDTH  = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic                    STOP,
    input  logic [SIZE_WIDTH-1:0]   PACKET_SIZE,
    input  logic [CNT_WIDTH-1:0]    PACKET_LIMIT,
    input  logic [GAP_WIDTH-1:0]    GAP_CYCLES,
    output logic                    BUSY,
    output logic [CNT_WIDTH-1:0]    PACKET_CNT,
    output logic [8*BYTE_WIDTH-1:0] M_AXIS_TDATA,
    output logic [BYTE_WIDTH-1:0]   M_AXIS_TKEEP,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic                    M_AXIS_TLAST
);

    localparam int unsigned DATA_W = 8 * BYTE_WIDTH;
    // One extra bit so offset + BYTE_WIDTH never wraps for the largest size.
    localparam int unsigned OFF_W  = SIZE_WIDTH + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]            state,     state_nxt;
    logic [SIZE_WIDTH-1:0] size_q,    size_nxt;
    logic [CNT_WIDTH-1:0]  limit_q,   limit_nxt;
    logic [GAP_WIDTH-1:0]  gap_q,     gap_nxt;
    logic [CNT_WIDTH-1:0]  run_cnt,   run_nxt;
    logic [OFF_W-1:0]      off_q,     off_nxt;
    logic [GAP_WIDTH-1:0]  gap_cnt,   gcnt_nxt;
    logic                  stop_seen, stop_nxt;
    logic                  busy_nxt;
    logic [CNT_WIDTH-1:0]  pcnt_nxt;
    logic                  load_beat;
    logic                  clr_beat;

    logic [DATA_W-1:0]     bd_data;
    logic [BYTE_WIDTH-1:0] bd_keep;
    logic                  bd_last;

    // Next-state and control decode; a loaded beat is built from off/size/pcnt next values.
    always_comb begin
        state_nxt = state;
        size_nxt  = size_q;
        limit_nxt = limit_q;
        gap_nxt   = gap_q;
        run_nxt   = run_cnt;
        off_nxt   = off_q;
        gcnt_nxt  = gap_cnt;
        stop_nxt  = stop_seen;
        busy_nxt  = BUSY;
        pcnt_nxt  = PACKET_CNT;
        load_beat = 1'b0;
        clr_beat  = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_DATA;
                    busy_nxt  = 1'b1;
                    size_nxt  = (PACKET_SIZE == '0) ? SIZE_WIDTH'(1) : PACKET_SIZE;
                    limit_nxt = PACKET_LIMIT;
                    gap_nxt   = GAP_CYCLES;
                    run_nxt   = '0;
                    off_nxt   = '0;
                    stop_nxt  = STOP;
                    load_beat = 1'b1;
                end
            end
            S_DATA: begin
                stop_nxt = stop_seen | STOP;
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (M_AXIS_TLAST) begin
                        pcnt_nxt = PACKET_CNT + CNT_WIDTH'(1);
                        run_nxt  = run_cnt + CNT_WIDTH'(1);
                        off_nxt  = '0;
                        if (((limit_q != '0) && (run_nxt == limit_q)) || stop_seen || STOP) begin
                            state_nxt = S_IDLE;
                            busy_nxt  = 1'b0;
                            stop_nxt  = 1'b0;
                            clr_beat  = 1'b1;
                        end else if (gap_q == '0) begin
                            load_beat = 1'b1;
                        end else begin
                            state_nxt = S_GAP;
                            gcnt_nxt  = gap_q;
                            clr_beat  = 1'b1;
                        end
                    end else begin
                        off_nxt   = off_q + OFF_W'(BYTE_WIDTH);
                        load_beat = 1'b1;
                    end
                end
            end
            S_GAP: begin
                stop_nxt = stop_seen | STOP;
                if (gap_cnt <= GAP_WIDTH'(1)) begin
                    if (stop_seen || STOP) begin
                        state_nxt = S_IDLE;
                        busy_nxt  = 1'b0;
                        stop_nxt  = 1'b0;
                    end else begin
                        state_nxt = S_DATA;
                        load_beat = 1'b1;
                    end
                end else begin
                    gcnt_nxt = gap_cnt - GAP_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
                stop_nxt  = 1'b0;
                clr_beat  = 1'b1;
            end
        endcase
    end

`ifdef AXIS_PKT_GEN_SEQ_HEADER_EN
    localparam int unsigned HDR_BYTES = (BYTE_WIDTH < 4) ? BYTE_WIDTH : 4;
    logic [31:0] hdr_cnt;
    assign hdr_cnt = 32'(pcnt_nxt);
`endif

    // Beat builder: bytes below the packet size carry their byte index, the rest are zero.
    always_comb begin
        logic [OFF_W-1:0] pos;
        pos     = '0;
        bd_data = '0;
        bd_keep = '0;
        for (int unsigned i = 0; i < BYTE_WIDTH; i++) begin
            pos = off_nxt + OFF_W'(i);
            if (pos < {1'b0, size_nxt}) begin
                bd_keep[i]        = 1'b1;
                bd_data[8*i +: 8] = pos[7:0];
            end
        end
`ifdef AXIS_PKT_GEN_SEQ_HEADER_EN
        for (int unsigned i = 0; i < HDR_BYTES; i++) begin
            if ((off_nxt == '0) && bd_keep[i]) begin
                bd_data[8*i +: 8] = hdr_cnt[8*i +: 8];
            end
        end
`endif
        bd_last = (({1'b0, size_nxt} - off_nxt) <= OFF_W'(BYTE_WIDTH));
    end

    // State, configuration and registered AXIS outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= S_IDLE;
            size_q        <= '0;
            limit_q       <= '0;
            gap_q         <= '0;
            run_cnt       <= '0;
            off_q         <= '0;
            gap_cnt       <= '0;
            stop_seen     <= 1'b0;
            BUSY          <= 1'b0;
            PACKET_CNT    <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TKEEP  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end else begin
            state      <= state_nxt;
            size_q     <= size_nxt;
            limit_q    <= limit_nxt;
            gap_q      <= gap_nxt;
            run_cnt    <= run_nxt;
            off_q      <= off_nxt;
            gap_cnt    <= gcnt_nxt;
            stop_seen  <= stop_nxt;
            BUSY       <= busy_nxt;
            PACKET_CNT <= pcnt_nxt;
            if (load_beat) begin
                M_AXIS_TVALID <= 1'b1;
                M_AXIS_TDATA  <= bd_data;
                M_AXIS_TKEEP  <= bd_keep;
                M_AXIS_TLAST  <= bd_last;
            end else if (clr_beat) begin
                M_AXIS_TVALID <= 1'b0;
                M_AXIS_TDATA  <= '0;
                M_AXIS_TKEEP  <= '0;
                M_AXIS_TLAST  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: directed runs, a beat-level model queue and a
// per-cycle compare process (payload, TKEEP, TLAST, gaps, stall stability).
module tb_axis_pkt_gen;

    localparam int BW = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic [15:0] PACKET_SIZE = '0;
    logic [31:0] PACKET_LIMIT = '0;
    logic [7:0]  GAP_CYCLES = '0;
    logic        BUSY;
    logic [31:0] PACKET_CNT;
    logic [31:0] M_AXIS_TDATA;
    logic [3:0]  M_AXIS_TKEEP;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY = 1'b1;
    logic        M_AXIS_TLAST;

    always #5 CLK = ~CLK;

    axis_pkt_gen #(.BYTE_WIDTH(4), .SIZE_WIDTH(16), .CNT_WIDTH(32), .GAP_WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP),
        .PACKET_SIZE(PACKET_SIZE), .PACKET_LIMIT(PACKET_LIMIT), .GAP_CYCLES(GAP_CYCLES),
        .BUSY(BUSY), .PACKET_CNT(PACKET_CNT),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TLAST(M_AXIS_TLAST)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          gap;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       log_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = '0;
    bit          rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected beats of npkts packets straight from the byte-index rule.
    task automatic push_pkts(input int size, input int npkts, input int gap);
        int s;
        int n;
        s = (size == 0) ? 1 : size;
        n = (s + BW - 1) / BW;
        for (int p = 0; p < npkts; p++) begin
            for (int b = 0; b < n; b++) begin
                beat_t e;
                e.data = '0;
                e.keep = '0;
                for (int i = 0; i < BW; i++) begin
                    int idx;
                    idx = b * BW + i;
                    if (idx < s) begin
                        e.keep[i] = 1'b1;
                        e.data[8*i +: 8] = 8'(idx % 256);
`ifdef AXIS_PKT_GEN_SEQ_HEADER_EN
                        if (b == 0) e.data[8*i +: 8] = model_cnt[8*i +: 8];
`endif
                    end
                end
                e.last = (b == n - 1);
                e.gap  = (b == 0 && p > 0) ? gap : -1;
                exp_q.push_back(e);
            end
            model_cnt = model_cnt + 32'd1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start_run(input int size, input int limit, input int gap, input bit stop);
        PACKET_SIZE  = 16'(size);
        PACKET_LIMIT = 32'(limit);
        GAP_CYCLES   = 8'(gap);
        START = 1'b1;
        STOP  = stop;
        step(1);
        START = 1'b0;
        STOP  = 1'b0;
    endtask

    task automatic end_run(input string name);
        int n;
        n = 0;
        while (BUSY && n < 2000) begin
            step(1);
            n++;
        end
        check({name, "_idle"}, 64'(BUSY), 64'(0));
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'(0));
        check({name, "_pkt_cnt"}, 64'(PACKET_CNT), 64'(model_cnt));
    endtask

    task automatic wait_log(input int k);
        int n;
        n = 0;
        while (log_q.size() < k && n < 2000) begin
            step(1);
            n++;
        end
        check("wait_beats", 64'(log_q.size() >= k), 64'(1));
    endtask

    // Downstream ready: fixed high, or a coin flip each cycle.
    always @(posedge CLK) begin
        #1;
        M_AXIS_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Per-cycle compare against the model queue.
    bit    prev_stall = 1'b0;
    beat_t prev_b;
    beat_t got_b;
    int    idle = 0;
    always @(negedge CLK) begin
        if (RESET) begin
            prev_stall = 1'b0;
            idle = 0;
        end else begin
            got_b.data = M_AXIS_TDATA;
            got_b.keep = M_AXIS_TKEEP;
            got_b.last = M_AXIS_TLAST;
            got_b.gap  = 0;
            if (prev_stall) begin
                check("stall_tvalid", 64'(M_AXIS_TVALID), 64'(1));
                check("stall_tdata", 64'(got_b.data), 64'(prev_b.data));
                check("stall_tkeep", 64'(got_b.keep), 64'(prev_b.keep));
                check("stall_tlast", 64'(got_b.last), 64'(prev_b.last));
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(got_b.data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_tdata", 64'(got_b.data), 64'(e.data));
                    check("beat_tkeep", 64'(got_b.keep), 64'(e.keep));
                    check("beat_tlast", 64'(got_b.last), 64'(e.last));
                    if (e.gap >= 0) check("gap_cycles", 64'(idle), 64'(e.gap));
                end
                log_q.push_back(got_b);
                if (M_AXIS_TLAST) idle = 0;
            end else if (!M_AXIS_TVALID) begin
                idle++;
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_b = got_b;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        step(3);
        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_pkt_cnt", 64'(PACKET_CNT), 64'(0));
        check("rst_tdata", 64'(M_AXIS_TDATA), 64'(0));
        check("rst_tkeep", 64'(M_AXIS_TKEEP), 64'(0));
        check("rst_tlast", 64'(M_AXIS_TLAST), 64'(0));
        RESET = 1'b0;
        step(1);

        // 1) 10 bytes, one packet, always ready; latency 1 after START
        log_q.delete();
        push_pkts(10, 1, 0);
        start_run(10, 1, 0, 1'b0);
        check("t1_busy_lat", 64'(BUSY), 64'(1));
        check("t1_tvalid_lat", 64'(M_AXIS_TVALID), 64'(1));
        end_run("t1");
        check("t1_pkt_cnt_lit", 64'(PACKET_CNT), 64'(1));
        check("t1_nbeats", 64'(log_q.size()), 64'(3));
`ifndef AXIS_PKT_GEN_SEQ_HEADER_EN
        if (log_q.size() == 3) begin
            check("t1_b0_data", 64'(log_q[0].data), 64'h0302_0100);
            check("t1_b0_keep", 64'(log_q[0].keep), 64'hF);
            check("t1_b1_data", 64'(log_q[1].data), 64'h0706_0504);
            check("t1_b2_data", 64'(log_q[2].data), 64'h0000_0908);
            check("t1_b2_keep", 64'(log_q[2].keep), 64'h3);
            check("t1_b2_last", 64'(log_q[2].last), 64'h1);
        end
`endif

        // 2) same packet with random backpressure
        rand_rdy = 1'b1;
        push_pkts(10, 1, 0);
        start_run(10, 1, 0, 1'b0);
        end_run("t2");

        // 3) 3 packets of 8 bytes, gap 2
        rand_rdy = 1'b0;
        step(1);
        push_pkts(8, 3, 2);
        start_run(8, 3, 2, 1'b0);
        end_run("t3");
        check("t3_pkt_cnt_lit", 64'(PACKET_CNT), 64'(5));

        // 3b) odd size, gap 3, with backpressure
        rand_rdy = 1'b1;
        push_pkts(7, 2, 3);
        start_run(7, 2, 3, 1'b0);
        end_run("t3b");
        rand_rdy = 1'b0;
        step(1);

        // 4) unlimited run ended by STOP during packet 2
        log_q.delete();
        push_pkts(16, 2, 1);
        start_run(16, 0, 1, 1'b0);
        wait_log(5);
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        end_run("t4");
        step(5);
        check("t4_no_pkt3", 64'(M_AXIS_TVALID), 64'(0));
        check("t4_nbeats", 64'(log_q.size()), 64'(8));

        // STOP while idle must not shorten the next run
        STOP = 1'b1;
        step(2);
        check("idle_stop_busy", 64'(BUSY), 64'(0));
        STOP = 1'b0;
        push_pkts(4, 2, 0);
        start_run(4, 2, 0, 1'b0);
        end_run("idle_stop");

        // START with STOP in the same cycle: exactly one packet
        push_pkts(5, 1, 0);
        start_run(5, 0, 0, 1'b1);
        end_run("start_stop");

        // 5) reset in the middle of a packet
        log_q.delete();
        push_pkts(16, 1, 0);
        start_run(16, 1, 0, 1'b0);
        wait_log(1);
        RESET = 1'b1;
        step(1);
        check("t5_tvalid", 64'(M_AXIS_TVALID), 64'(0));
        check("t5_busy", 64'(BUSY), 64'(0));
        check("t5_pkt_cnt", 64'(PACKET_CNT), 64'(0));
        exp_q.delete();
        model_cnt = '0;
        RESET = 1'b0;
        step(1);
        log_q.delete();
        push_pkts(8, 1, 0);
        start_run(8, 1, 0, 1'b0);
        end_run("t5b");
`ifndef AXIS_PKT_GEN_SEQ_HEADER_EN
        if (log_q.size() > 0) check("t5_restart_data", 64'(log_q[0].data), 64'h0302_0100);
`endif

        // 6) size 0 behaves as a single byte
        log_q.delete();
        push_pkts(0, 1, 0);
        start_run(0, 1, 0, 1'b0);
        end_run("t6");
        check("t6_nbeats", 64'(log_q.size()), 64'(1));
        if (log_q.size() > 0) begin
            check("t6_keep", 64'(log_q[0].keep), 64'h1);
            check("t6_last", 64'(log_q[0].last), 64'h1);
`ifndef AXIS_PKT_GEN_SEQ_HEADER_EN
            check("t6_data", 64'(log_q[0].data), 64'h0);
`endif
        end

`ifdef AXIS_PKT_GEN_SEQ_HEADER_EN
        // 6b) sequence header from reset
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
        exp_q.delete();
        model_cnt = '0;
        step(1);
        log_q.delete();
        push_pkts(8, 2, 0);
        start_run(8, 2, 0, 1'b0);
        end_run("t6_hdr");
        if (log_q.size() == 4) begin
            check("t6_hdr_p0", 64'(log_q[0].data), 64'h0000_0000);
            check("t6_hdr_p1", 64'(log_q[2].data), 64'h0000_0001);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
